// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD controller and its command feeder:
// image command encodings and the feeder state machine encoding.
package lcd_pkg;

    localparam int CMD_W = 3;

    // Image commands understood by the LCD controller
    typedef enum logic [CMD_W-1:0] {
        CMD_WRITE    = 3'd0,
        CMD_UP       = 3'd1,
        CMD_DOWN     = 3'd2,
        CMD_LEFT     = 3'd3,
        CMD_RIGHT    = 3'd4,
        CMD_AVG      = 3'd5,
        CMD_MIRROR_X = 3'd6,
        CMD_MIRROR_Y = 3'd7
    } lcd_cmd_e;

    // Command feeder sequencing states
    typedef enum logic [2:0] {
        ST_WAIT_READY = 3'd0,
        ST_IDLE       = 3'd1,
        ST_WAIT_ACK   = 3'd2,
        ST_WAIT_BUSY  = 3'd3,
        ST_HALT       = 3'd4,
        ST_FINISHED   = 3'd5
    } feeder_state_e;

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Synchronous command FIFO, DEPTH x CMD_W, first-word fall-through head.
// Push is refused when full and pop when empty; flush empties it in one cycle.
module lcd_cmd_fifo
    import lcd_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [CMD_W-1:0]           din,
    output logic [CMD_W-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [CMD_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt_q;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (cnt_q == FULL_CNT);
    assign empty   = (cnt_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];
    assign count   = cnt_q;

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage array; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/lcd_cmd_feeder.sv
// Upstream command stage for the LCD controller. Queues host commands and
// issues them one at a time as single-cycle pulses while the controller is
// idle; stops after WRITE is acknowledged and reports completion on done.
module lcd_cmd_feeder
    import lcd_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int ACK_TIMEOUT = 4,
    parameter int CNT_W       = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [CMD_W-1:0]           host_cmd,
    input  logic                       host_valid,
    output logic                       host_ready,
    input  logic                       busy,
    input  logic                       done,
    output logic [CMD_W-1:0]           cmd,
    output logic                       cmd_valid,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic [CNT_W-1:0]           issued_cnt,
    output logic                       seq_done,
    output logic                       err
);

    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(ACK_TIMEOUT - 1);

    feeder_state_e    state_q, state_d;
    logic [CMD_W-1:0] cmd_q, cmd_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic [CNT_W-1:0] issued_q, issued_d;
    logic             seq_done_q, seq_done_d;
    logic             err_q, err_d;
    logic [TW-1:0]    to_cnt_q, to_cnt_d;
    logic             ready_seen_q, ready_seen_d;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_flush;
    logic [CMD_W-1:0] fifo_head;
    logic             fifo_full;
    logic             fifo_empty;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Readiness uses the registered count, so a push against a full FIFO is
    // refused even if a pop happens in the same cycle.
    assign host_ready = !fifo_full && (state_q != ST_HALT) && (state_q != ST_FINISHED);
    assign fifo_push  = host_valid && host_ready;
    assign fifo_flush = (state_q == ST_HALT);

    lcd_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .din   (host_cmd),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_WAIT_READY;
            cmd_q        <= '0;
            cmd_valid_q  <= 1'b0;
            issued_q     <= '0;
            seq_done_q   <= 1'b0;
            err_q        <= 1'b0;
            to_cnt_q     <= '0;
            ready_seen_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            cmd_valid_q  <= cmd_valid_d;
            issued_q     <= issued_d;
            seq_done_q   <= seq_done_d;
            err_q        <= err_d;
            to_cnt_q     <= to_cnt_d;
            ready_seen_q <= ready_seen_d;
        end
    end

    // Next-state, issue, timeout and error decisions
    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        cmd_valid_d  = 1'b0;
        issued_d     = issued_q;
        seq_done_d   = seq_done_q;
        err_d        = err_q;
        to_cnt_d     = to_cnt_q;
        ready_seen_d = ready_seen_q;
        fifo_pop     = 1'b0;

        // done is only legal once WRITE has been acknowledged
        if (done && (state_q != ST_HALT) && (state_q != ST_FINISHED)) begin
            err_d   = 1'b1;
            state_d = ST_FINISHED;
        end else begin
            case (state_q)
                ST_WAIT_READY: begin
                    // Two consecutive idle cycles mark the end of the initial load
                    if (!busy) begin
                        if (ready_seen_q) state_d = ST_IDLE;
                        ready_seen_d = 1'b1;
                    end else begin
                        ready_seen_d = 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (!fifo_empty && !busy) begin
                        fifo_pop    = 1'b1;
                        cmd_d       = fifo_head;
                        cmd_valid_d = 1'b1;
                        issued_d    = sat_inc(issued_q);
                        to_cnt_d    = '0;
                        state_d     = ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    // An unacknowledged command is dropped, not retried
                    if (busy) begin
                        state_d = ST_WAIT_BUSY;
                    end else if (to_cnt_q == TO_LAST) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
                ST_WAIT_BUSY: begin
                    if (!busy) state_d = (cmd_q == CMD_WRITE) ? ST_HALT : ST_IDLE;
                end
                ST_HALT: begin
                    if (done) begin
                        seq_done_d = 1'b1;
                        state_d    = ST_FINISHED;
                    end
                end
                ST_FINISHED: begin
                    state_d = ST_FINISHED;
                end
                default: begin
                    state_d = ST_WAIT_READY;
                end
            endcase
        end
    end

    assign cmd        = cmd_q;
    assign cmd_valid  = cmd_valid_q;
    assign issued_cnt = issued_q;
    assign seq_done   = seq_done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_lcd_cmd_feeder.sv
// Directed bench for lcd_cmd_feeder: a table of push vectors for FIFO fill
// behaviour plus hand-written sequences for issue, ack timeout, halt and reset.
module tb_lcd_cmd_feeder;

    localparam int DEPTH       = 8;
    localparam int ACK_TIMEOUT = 4;
    localparam int CNT_W       = 8;
    localparam int CW          = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [2:0]       host_cmd;
    logic             host_valid;
    logic             host_ready;
    logic             busy;
    logic             done;
    logic [2:0]       cmd;
    logic             cmd_valid;
    logic [CW-1:0]    fifo_count;
    logic [CNT_W-1:0] issued_cnt;
    logic             seq_done;
    logic             err;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;
    bit model_on  = 1'b0;
    int model_cnt = 0;
    logic [2:0] log_cmd[$];
    int         log_cyc[$];

    typedef struct {
        logic       v;
        logic [2:0] c;
        int         exp_cnt;
        int         exp_rdy;
    } vec_t;
    vec_t tbl[10];

    lcd_cmd_feeder #(
        .DEPTH       (DEPTH),
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .host_cmd   (host_cmd),
        .host_valid (host_valid),
        .host_ready (host_ready),
        .busy       (busy),
        .done       (done),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .fifo_count (fifo_count),
        .issued_cnt (issued_cnt),
        .seq_done   (seq_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    // One clock; sample 1 time unit after the edge, log pulses, run the
    // controller model (busy high for two cycles after each pulse).
    task automatic step();
        @(posedge clk);
        #1;
        cycle++;
        if (cmd_valid) begin
            log_cmd.push_back(cmd);
            log_cyc.push_back(cycle);
        end
        if (model_on) begin
            if (cmd_valid) model_cnt = 2;
            else if (model_cnt > 0) model_cnt--;
            busy = (model_cnt > 0);
        end
    endtask

    task automatic push(input logic [2:0] c);
        host_cmd   = c;
        host_valid = 1'b1;
        step();
        host_valid = 1'b0;
    endtask

    task automatic do_reset();
        model_on   = 1'b0;
        model_cnt  = 0;
        host_valid = 1'b0;
        host_cmd   = 3'd0;
        done       = 1'b0;
        reset      = 1'b1;
        step();
        step();
        reset = 1'b0;
        log_cmd.delete();
        log_cyc.delete();
    endtask

    initial begin
        int k;
        busy = 1'b1;
        do_reset();

        // Reset state
        check("rst_host_ready", int'(host_ready), 1);
        check("rst_fifo_count", int'(fifo_count), 0);
        check("rst_cmd_valid", int'(cmd_valid), 0);
        check("rst_cmd", int'(cmd), 0);
        check("rst_issued", int'(issued_cnt), 0);
        check("rst_seq_done", int'(seq_done), 0);
        check("rst_err", int'(err), 0);

        // 1: long initial load, then one LEFT command
        busy = 1'b1;
        push(3'd3);
        repeat (69) step();
        check("t1_count_queued", int'(fifo_count), 1);
        check("t1_no_issue_busy", log_cmd.size(), 0);
        busy      = 1'b0;
        model_cnt = 0;
        model_on  = 1'b1;
        k = 21;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (cmd_valid) begin
                k = i;
                break;
            end
        end
        check("t1_issue_latency", k, 3);
        check("t1_cmd", int'(cmd), 3);
        check("t1_issued", int'(issued_cnt), 1);
        check("t1_count_after", int'(fifo_count), 0);
        step();
        check("t1_pulse_one_cycle", int'(cmd_valid), 0);
        check("t1_cmd_held", int'(cmd), 3);
        repeat (8) step();

        // 2: queue four while busy, then drain through the controller model
        model_on = 1'b0;
        busy     = 1'b1;
        log_cmd.delete();
        log_cyc.delete();
        push(3'd1);
        push(3'd5);
        push(3'd6);
        push(3'd0);
        check("t2_count4", int'(fifo_count), 4);
        check("t2_no_issue_busy", log_cmd.size(), 0);
        busy      = 1'b0;
        model_cnt = 0;
        model_on  = 1'b1;
        repeat (40) step();
        check("t2_pulses", log_cmd.size(), 4);
        if (log_cmd.size() == 4) begin
            check("t2_cmd0", int'(log_cmd[0]), 1);
            check("t2_cmd1", int'(log_cmd[1]), 5);
            check("t2_cmd2", int'(log_cmd[2]), 6);
            check("t2_cmd3", int'(log_cmd[3]), 0);
            for (int i = 1; i < 4; i++)
                check($sformatf("t2_gap%0d", i), log_cyc[i] - log_cyc[i-1], 4);
        end
        check("t2_halt_ready", int'(host_ready), 0);
        check("t2_issued", int'(issued_cnt), 5);
        check("t2_seq_done", int'(seq_done), 0);
        check("t2_err", int'(err), 0);

        // 5: in HALT pushes are ignored; done completes the sequence
        host_cmd   = 3'd5;
        host_valid = 1'b1;
        step();
        step();
        host_valid = 1'b0;
        check("t5_count_halt", int'(fifo_count), 0);
        check("t5_ready_halt", int'(host_ready), 0);
        done = 1'b1;
        step();
        done = 1'b0;
        check("t5_seq_done", int'(seq_done), 1);
        check("t5_err", int'(err), 0);
        log_cmd.delete();
        log_cyc.delete();
        host_cmd   = 3'd2;
        host_valid = 1'b1;
        repeat (10) step();
        host_valid = 1'b0;
        check("t5_no_pulse", log_cmd.size(), 0);
        check("t5_count_fin", int'(fifo_count), 0);
        check("t5_ready_fin", int'(host_ready), 0);
        check("t5_seq_sticky", int'(seq_done), 1);

        // 3: fill the FIFO during WAIT_READY, ninth push refused
        busy = 1'b1;
        do_reset();
        tbl[0] = '{1'b1, 3'd4, 1, 1};
        tbl[1] = '{1'b1, 3'd2, 2, 1};
        tbl[2] = '{1'b1, 3'd7, 3, 1};
        tbl[3] = '{1'b1, 3'd1, 4, 1};
        tbl[4] = '{1'b1, 3'd3, 5, 1};
        tbl[5] = '{1'b1, 3'd5, 6, 1};
        tbl[6] = '{1'b1, 3'd6, 7, 1};
        tbl[7] = '{1'b1, 3'd0, 8, 0};
        tbl[8] = '{1'b1, 3'd7, 8, 0};
        tbl[9] = '{1'b0, 3'd1, 8, 0};
        for (int i = 0; i < 10; i++) begin
            host_valid = tbl[i].v;
            host_cmd   = tbl[i].c;
            step();
            host_valid = 1'b0;
            check($sformatf("t3_count_v%0d", i), int'(fifo_count), tbl[i].exp_cnt);
            check($sformatf("t3_ready_v%0d", i), int'(host_ready), tbl[i].exp_rdy);
        end

        // 4: controller never acknowledges; timeout then next command
        busy = 1'b0;
        step();
        check("t4_wait1", int'(cmd_valid), 0);
        step();
        check("t4_wait2", int'(cmd_valid), 0);
        step();
        check("t4_issue", int'(cmd_valid), 1);
        check("t4_cmd", int'(cmd), 4);
        check("t4_count7", int'(fifo_count), 7);
        for (int i = 1; i <= 4; i++) begin
            step();
            if (i == 3) check("t4_err_early", int'(err), 0);
            if (i == 4) check("t4_err_timeout", int'(err), 1);
        end
        step();
        check("t4_next_issue", int'(cmd_valid), 1);
        check("t4_next_cmd", int'(cmd), 2);
        check("t4_count6", int'(fifo_count), 6);
        check("t4_issued2", int'(issued_cnt), 2);

        // 6: asynchronous reset while waiting for busy to fall
        busy = 1'b1;
        do_reset();
        push(3'd1);
        push(3'd2);
        push(3'd3);
        push(3'd4);
        busy = 1'b0;
        step();
        step();
        step();
        check("t6_issue", int'(cmd_valid), 1);
        busy = 1'b1;
        step();
        step();
        check("t6_count3", int'(fifo_count), 3);
        #2;
        reset = 1'b1;
        #1;
        check("t6_count_rst", int'(fifo_count), 0);
        check("t6_valid_rst", int'(cmd_valid), 0);
        check("t6_err_rst", int'(err), 0);
        check("t6_seq_rst", int'(seq_done), 0);
        check("t6_issued_rst", int'(issued_cnt), 0);
        check("t6_ready_rst", int'(host_ready), 1);
        step();
        reset = 1'b0;

        // 7: done before any WRITE is an error and terminates
        done = 1'b1;
        step();
        done = 1'b0;
        check("t7_err", int'(err), 1);
        check("t7_ready", int'(host_ready), 0);
        check("t7_seq_done", int'(seq_done), 0);
        step();
        check("t7_err_sticky", int'(err), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
